instr_seq_ctrl: RTL
===================

// Module: instr_seq_ctrl
// PURPOSE
//  Multi-cycle sequencing FSM for the RISC-V core. Steps each instruction through FETCH, DECODE, EXEC,
//  MEM and WB, using the decoder's opcode/fun3 fields. Drives instruction/data memory handshakes,
//  PC/IR/regfile write enables and datapath mux selects. Traps on illegal opcode or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for imem/dmem ready before trap; 0 disables timeout
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk           in   1      core clock
//  rst           in   1      reset, asynchronous, active-high
//  run           in   1      1 = execute; sampled at instruction boundaries only
//  opcode        in   7      decoded opcode (valid from DECODE onward, IR held stable)
//  fun3          in   3      decoded fun3 (passed through to memory width logic elsewhere)
//  branch_taken  in   1      branch comparator result, valid in EXEC
//  imem_ready    in   1      instruction memory data valid
//  dmem_ready    in   1      data memory access complete
//  trap_clr      in   1      clears sticky trap, returns FSM to IDLE
//  imem_req      out  1      instruction fetch request
//  ir_we         out  1      instruction register write strobe
//  pc_we         out  1      PC update strobe
//  pc_sel        out  2      0 pc+4, 1 branch/JAL target, 2 JALR target
//  reg_we        out  1      register-file write strobe
//  wb_sel        out  2      0 ALU, 1 load data, 2 pc+4, 3 immediate (LUI)
//  alu_src_imm   out  1      1 = ALU operand B from immediate
//  dmem_req      out  1      data memory request
//  dmem_we       out  1      data memory write (store)
//  busy          out  1      1 when state != IDLE and != TRAP
//  trap          out  1      sticky trap flag
//  trap_cause    out  2      0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//  retired       out  CNT_W  count of completed instructions (wraps modulo 2^CNT_W)
//  state         out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
// BEHAVIOUR
//  - Reset: state=IDLE, trap=0, trap_cause=0, retired=0, wait counter=0; all strobes/selects 0.
//  - Strobes are combinational from state+inputs; only state, trap, cause, retired, wait counter are flops.
//  - IDLE: run=1 -> FETCH, else stay.
//  - FETCH: imem_req=1. imem_ready=1 -> ir_we=1 same cycle, -> DECODE. Else wait counter++;
//    counter reaching MEM_TIMEOUT -> TRAP, cause=2. Counter cleared on every state change.
//  - DECODE: legal opcodes 0110011,0010011,0000011,0100011,1100011,0110111,0010111,1101111,1100111
//    -> EXEC; any other -> TRAP, cause=1. No strobes.
//  - EXEC: alu_src_imm=1 for all except R-type and branch. Next:
//    load/store -> MEM; R/I/LUI/AUIPC/JAL/JALR -> WB;
//    branch -> pc_we=1, pc_sel=branch_taken?1:0, retire, -> boundary.
//  - MEM: dmem_req=1, dmem_we=1 for store. dmem_ready=1: load -> WB; store -> pc_we=1,
//    pc_sel=0, retire, -> boundary. Timeout as FETCH, cause=3.
//  - WB: reg_we=1; wb_sel = 1 load, 2 JAL/JALR, 3 LUI, else 0; pc_we=1,
//    pc_sel = 1 JAL, 2 JALR, else 0; retire, -> boundary.
//  - Boundary: run=1 -> FETCH, run=0 -> IDLE. run changes mid-instruction have no effect.
//  - Retire: retired increments by exactly 1 on every pc_we cycle; 2^CNT_W-1 wraps to 0.
//  - TRAP: all strobes 0, trap=1 and cause held; retired frozen. trap_clr=1 -> IDLE, trap=0, cause=0.
//    trap_clr ignored outside TRAP.
//  - Latency with ready=1 on first request cycle: branch 3, R/I/U/J 4, store 4, load 5 cycles.
//  - Async reset mid-instruction aborts immediately; no strobe is emitted after rst rises.
// TESTING
//  1 R-type 0110011, run=1, imem_ready=1 -> states 1,2,3,5; reg_we=1 and wb_sel=0 in WB; retired=1 after 4 cycles.
//  2 Load 0000011, dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, then WB with wb_sel=1; total 8 cycles.
//  3 Branch, branch_taken=1 -> pc_we=1, pc_sel=1 in EXEC, no reg_we; then JALR -> WB pc_sel=2, wb_sel=2.
//  4 Opcode 7'b1111111 -> TRAP, cause=1, strobes 0; trap_clr -> IDLE, trap=0.
//  5 imem_ready held 0, MEM_TIMEOUT=15 -> TRAP cause=2 after 15 FETCH wait cycles; MEM_TIMEOUT=0 -> never traps.
//  6 Drop run during MEM of store -> store completes, then IDLE; assert rst during EXEC -> IDLE, retired=0.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Drives memory handshakes, datapath strobes, retire count and sticky trap.
module instr_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       fun3,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int WAIT_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TO_LAST);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t             st_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               trap_q;
  logic [1:0]         cause_q;
  logic [CNT_W-1:0]   ret_q;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_legal;
  state_t bound_st;

  // fun3 is consumed by the memory width logic, not by sequencing
  logic unused_fun3;
  assign unused_fun3 = ^fun3;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  assign is_legal = is_r | is_i | is_ld | is_st | is_br
                  | is_lui | is_auipc | is_jal | is_jalr;

  // run is only looked at when an instruction retires
  assign bound_st = run ? S_FETCH : S_IDLE;

  // strobes and selects decoded from current state and handshakes
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    unique case (st_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        alu_src_imm = ~(is_r | is_br);
        if (is_br) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ready && is_st) begin
          pc_we = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        unique case (1'b1)
          is_ld:             wb_sel = 2'd1;
          (is_jal|is_jalr):  wb_sel = 2'd2;
          is_lui:            wb_sel = 2'd3;
          default:           wb_sel = 2'd0;
        endcase
        unique case (1'b1)
          is_jal:  pc_sel = 2'd1;
          is_jalr: pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
      end
      default: begin
      end
    endcase
  end

  // sequencer state, wait counter, trap flags and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
      ret_q   <= '0;
    end else begin
      wait_q <= '0;
      if (pc_we) begin
        ret_q <= ret_q + CNT_W'(1);
      end
      unique case (st_q)
        S_IDLE: begin
          if (run) st_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            st_q <= S_DECODE;
          end else if (TO_EN && wait_q == WAIT_LAST) begin
            st_q    <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'd2;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            st_q <= S_EXEC;
          end else begin
            st_q    <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'd1;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            (is_ld|is_st): st_q <= S_MEM;
            is_br:         st_q <= bound_st;
            default:       st_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            st_q <= is_ld ? S_WB : bound_st;
          end else if (TO_EN && wait_q == WAIT_LAST) begin
            st_q    <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'd3;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          st_q <= bound_st;
        end
        S_TRAP: begin
          if (trap_clr) begin
            st_q    <= S_IDLE;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
          end
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (st_q != S_IDLE) && (st_q != S_TRAP);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = ret_q;
  assign state      = st_q;

endmodule
